// File: rtl/dpi_stream_sequencer.sv
// Flow-key to stream-ID sequencer feeding the regex matchers: restore strobe, payload bytes, end-of-packet strobe.
// Optional statistics counters are compiled in with DPI_SEQ_STATS_EN.
module dpi_stream_sequencer #(
    parameter int KEY_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_sop,
    input  logic             s_eop,
    input  logic [KEY_W-1:0] s_key,
    output logic             load_state,
    output logic [5:0]       stream_id,
    output logic             new_stream_id,
    output logic [7:0]       char_in,
    output logic             char_in_vld,
    output logic             eop
`ifdef DPI_SEQ_STATS_EN
    ,
    output logic [15:0]      pkt_cnt,
    output logic [15:0]      new_cnt,
    output logic [15:0]      drop_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, WAIT, STREAM, EOP} state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [63:0]      tbl_vld_q, tbl_vld_d;
    logic [KEY_W-1:0] tbl_key_q [64];
    logic [KEY_W-1:0] tbl_key_d [64];
    logic [5:0]       alloc_ptr_q, alloc_ptr_d;
    logic [1:0]       hold_q, hold_d;
    logic             load_state_q, load_state_d;
    logic [5:0]       stream_id_q, stream_id_d;
    logic             new_q, new_d;
    logic [7:0]       char_q, char_d;
    logic             char_vld_q, char_vld_d;
    logic             eop_q, eop_d;

    // A flush in the same cycle as a lookup clears the table first, then the lookup allocates.
    logic [63:0] live_vld;
    logic [5:0]  base_ptr;
    logic        hit;
    logic [5:0]  hit_idx;
    logic        drop_beat;
    logic        accept;

    assign live_vld  = flush ? 64'd0 : tbl_vld_q;
    assign base_ptr  = flush ? 6'd0 : alloc_ptr_q;
    assign drop_beat = (state_q == IDLE) && (hold_q == 2'd0) && s_valid && !s_sop;
    assign accept    = (state_q == STREAM) && s_valid;
    assign s_ready   = drop_beat || (state_q == STREAM);

    always_comb begin
        hit     = 1'b0;
        hit_idx = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (live_vld[i] && (tbl_key_q[i] == key_q) && !hit) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        tbl_vld_d    = live_vld;
        tbl_key_d    = tbl_key_q;
        alloc_ptr_d  = base_ptr;
        hold_d       = hold_q;
        load_state_d = 1'b0;
        stream_id_d  = stream_id_q;
        new_d        = new_q;
        char_d       = char_q;
        char_vld_d   = 1'b0;
        eop_d        = 1'b0;
        case (state_q)
            IDLE: begin
                // hold_q keeps the next restore at least four cycles behind eop
                if (hold_q != 2'd0) begin
                    hold_d = hold_q - 2'd1;
                end else if (s_valid && s_sop) begin
                    key_d   = s_key;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                // Strobe and ID are registered here so they are visible during LOAD
                load_state_d = 1'b1;
                state_d      = LOAD;
                if (hit) begin
                    stream_id_d = hit_idx;
                    new_d       = 1'b0;
                end else begin
                    stream_id_d         = base_ptr;
                    new_d               = 1'b1;
                    tbl_vld_d[base_ptr] = 1'b1;
                    tbl_key_d[base_ptr] = key_q;
                    alloc_ptr_d         = base_ptr + 6'd1;
                end
            end
            LOAD:   state_d = WAIT;
            WAIT:   state_d = STREAM;
            STREAM: begin
                if (accept) begin
                    char_d     = s_data;
                    char_vld_d = 1'b1;
                    if (s_eop) state_d = EOP;
                end
            end
            EOP: begin
                eop_d   = 1'b1;
                hold_d  = 2'd2;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            key_q        <= '0;
            tbl_vld_q    <= '0;
            alloc_ptr_q  <= '0;
            hold_q       <= '0;
            load_state_q <= 1'b0;
            stream_id_q  <= '0;
            new_q        <= 1'b0;
            char_q       <= '0;
            char_vld_q   <= 1'b0;
            eop_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            tbl_vld_q    <= tbl_vld_d;
            alloc_ptr_q  <= alloc_ptr_d;
            hold_q       <= hold_d;
            load_state_q <= load_state_d;
            stream_id_q  <= stream_id_d;
            new_q        <= new_d;
            char_q       <= char_d;
            char_vld_q   <= char_vld_d;
            eop_q        <= eop_d;
        end
    end

    // Key storage is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        tbl_key_q <= tbl_key_d;
    end

    assign load_state    = load_state_q;
    assign stream_id     = stream_id_q;
    assign new_stream_id = new_q;
    assign char_in       = char_q;
    assign char_in_vld   = char_vld_q;
    assign eop           = eop_q;

`ifdef DPI_SEQ_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] new_cnt_q, new_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        new_cnt_d  = new_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            pkt_cnt_d  = '0;
            new_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (eop_q && (pkt_cnt_q != 16'hFFFF))                 pkt_cnt_d  = pkt_cnt_q + 16'd1;
            if (load_state_q && new_q && (new_cnt_q != 16'hFFFF)) new_cnt_d  = new_cnt_q + 16'd1;
            if (drop_beat && (drop_cnt_q != 16'hFFFF))            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            new_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            new_cnt_q  <= new_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign new_cnt  = new_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Bench for dpi_stream_sequencer: random payloads checked against a flow-table map model.
module tb_dpi_stream_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_sop = 1'b0;
    logic        s_eop = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic [15:0] s_key = 16'd0;
    logic        s_ready, load_state, new_stream_id, char_in_vld, eop;
    logic [5:0]  stream_id;
    logic [7:0]  char_in;
`ifdef DPI_SEQ_STATS_EN
    logic [15:0] pkt_cnt, new_cnt, drop_cnt;
`endif

    dpi_stream_sequencer #(.KEY_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sop(s_sop), .s_eop(s_eop), .s_key(s_key),
        .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
        .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop)
`ifdef DPI_SEQ_STATS_EN
        , .pkt_cnt(pkt_cnt), .new_cnt(new_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int         ls_cyc[$];
    logic [5:0] ls_id[$];
    logic       ls_new[$];
    int         ch_cyc[$];
    logic [7:0] ch_dat[$];
    int         eop_cyc[$];
    logic [5:0] eop_id[$];
    logic [7:0] exp_bytes[$];
    int         prev_eop = -1000;

    always @(negedge clk) begin
        if (load_state) begin ls_cyc.push_back(cyc); ls_id.push_back(stream_id); ls_new.push_back(new_stream_id); end
        if (char_in_vld) begin ch_cyc.push_back(cyc); ch_dat.push_back(char_in); end
        if (eop) begin eop_cyc.push_back(cyc); eop_id.push_back(stream_id); end
    end

    // Reference flow table: key -> slot map with round-robin eviction
    int          slot_of[int];
    logic [15:0] slot_key[64];
    bit          slot_v[64];
    int          mptr = 0;

    task automatic model_lookup(input logic [15:0] k, output int id, output bit nw);
        if (slot_of.exists(int'(k))) begin
            id = slot_of[int'(k)];
            nw = 1'b0;
        end else begin
            id = mptr;
            nw = 1'b1;
            if (slot_v[mptr]) slot_of.delete(int'(slot_key[mptr]));
            slot_key[mptr] = k;
            slot_v[mptr] = 1'b1;
            slot_of[int'(k)] = mptr;
            mptr = (mptr + 1) % 64;
        end
    endtask

    task automatic model_flush();
        slot_of.delete();
        for (int i = 0; i < 64; i++) slot_v[i] = 1'b0;
        mptr = 0;
    endtask

    task automatic clear_mon();
        if (eop_cyc.size() > 0) prev_eop = eop_cyc[0];
        ls_cyc.delete(); ls_id.delete(); ls_new.delete();
        ch_cyc.delete(); ch_dat.delete(); eop_cyc.delete(); eop_id.delete();
        exp_bytes.delete();
    endtask

    task automatic drive_beat(input logic [7:0] d, input bit sop, input bit eb, input logic [15:0] k, output bit ok);
        int n = 0;
        ok = 1'b0;
        s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eb; s_key = k;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL handshake_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            @(posedge clk);
        end
        #1;
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic run_pkt(input logic [15:0] k, input int len, input bit gaps, input int flush_at,
                           input bit fixed_en, input logic [7:0] fixed);
        bit ok;
        int n = 0;
        logic [7:0] d;
        clear_mon();
        for (int i = 0; i < len; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if (i == flush_at) begin
                flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
            end
            d = fixed_en ? fixed : 8'($urandom);
            exp_bytes.push_back(d);
            drive_beat(d, i == 0, i == len - 1, k, ok);
        end
        while (eop_cyc.size() == 0 && n < 200) begin @(posedge clk); n++; end
        #1;
        if (eop_cyc.size() == 0) begin
            checks++; failures++;
            $display("FAIL eop_timeout: no eop within %0d cycles, required one", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_ready, load_state, new_stream_id, char_in_vld, eop, stream_id, char_in} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b ls=%b new=%b vld=%b eop=%b id=%0d ch=%h, required all 0",
                     s_ready, load_state, new_stream_id, char_in_vld, eop, stream_id, char_in);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [15:0] keys[3];
        int exp_id[3];
        bit exp_new[3];
        int mid;
        bit mnew, bytes_ok;
        keys[0] = 16'hA5A5; keys[1] = 16'hA5A5; keys[2] = 16'h0001;
        exp_id[0] = 0; exp_id[1] = 0; exp_id[2] = 1;
        exp_new[0] = 1; exp_new[1] = 0; exp_new[2] = 1;
        for (int p = 0; p < 3; p++) begin
            model_lookup(keys[p], mid, mnew);
            run_pkt(keys[p], 3, 1'b0, -1, 1'b0, 8'h00);
            checks++;
            if (ls_id.size() != 1 || ls_id[0] !== 6'(exp_id[p]) || ls_new[0] !== exp_new[p] || mid != exp_id[p]) begin
                failures++;
                $display("FAIL basic_load pkt%0d: got n=%0d id=%0d new=%b, required n=1 id=%0d new=%b",
                         p, ls_id.size(), ls_id[0], ls_new[0], exp_id[p], exp_new[p]);
            end
            bytes_ok = (ch_dat.size() == 3);
            for (int i = 0; i < ch_dat.size() && i < 3; i++) if (ch_dat[i] !== exp_bytes[i]) bytes_ok = 1'b0;
            checks++;
            if (!bytes_ok) begin
                failures++;
                $display("FAIL basic_bytes pkt%0d: got %0d bytes first=%h, required 3 bytes first=%h",
                         p, ch_dat.size(), ch_dat[0], exp_bytes[0]);
            end
            checks++;
            if (ch_cyc.size() != 3 || ls_cyc.size() != 1 || ch_cyc[0] != ls_cyc[0] + 3 || ch_cyc[2] != ch_cyc[0] + 2) begin
                failures++;
                $display("FAIL basic_latency pkt%0d: got ls@%0d char@%0d..%0d, required char@ls+3..ls+5",
                         p, ls_cyc[0], ch_cyc[0], ch_cyc[ch_cyc.size()-1]);
            end
            checks++;
            if (eop_cyc.size() != 1 || eop_cyc[0] != ch_cyc[ch_cyc.size()-1] + 1 || eop_id[0] !== 6'(exp_id[p])) begin
                failures++;
                $display("FAIL basic_eop pkt%0d: got eop@%0d id=%0d, required eop@%0d id=%0d",
                         p, eop_cyc[0], eop_id[0], ch_cyc[ch_cyc.size()-1] + 1, exp_id[p]);
            end
        end
    endtask

    task automatic test_single_beat();
        int mid;
        bit mnew;
        model_lookup(16'h3C3C, mid, mnew);
        run_pkt(16'h3C3C, 1, 1'b0, -1, 1'b1, 8'h41);
        checks++;
        if (ls_id.size() != 1 || ls_id[0] !== 6'(mid) || ls_new[0] !== mnew) begin
            failures++;
            $display("FAIL single_load: got id=%0d new=%b, required id=%0d new=%b", ls_id[0], ls_new[0], mid, mnew);
        end
        checks++;
        if (ch_dat.size() != 1 || ch_dat[0] !== 8'h41 || ch_cyc[0] != ls_cyc[0] + 3) begin
            failures++;
            $display("FAIL single_char: got n=%0d ch=%h @%0d, required n=1 ch=41 @%0d",
                     ch_dat.size(), ch_dat[0], ch_cyc[0], ls_cyc[0] + 3);
        end
        checks++;
        if (eop_cyc.size() != 1 || eop_cyc[0] != ch_cyc[0] + 1) begin
            failures++;
            $display("FAIL single_eop: got eop@%0d, required @%0d", eop_cyc[0], ch_cyc[0] + 1);
        end
    endtask

    task automatic test_idle_drop();
        bit ok;
        int acc = 0;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            drive_beat(8'($urandom), 1'b0, 1'($urandom), 16'h7777, ok);
            if (ok) acc++;
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (acc != 4 || ls_cyc.size() != 0 || ch_cyc.size() != 0 || eop_cyc.size() != 0) begin
            failures++;
            $display("FAIL idle_drop: got accepted=%0d ls=%0d chars=%0d eops=%0d, required 4 0 0 0",
                     acc, ls_cyc.size(), ch_cyc.size(), eop_cyc.size());
        end
`ifdef DPI_SEQ_STATS_EN
        checks++;
        if (drop_cnt !== 16'd4) begin
            failures++;
            $display("FAIL drop_cnt: got %0d, required 4", drop_cnt);
        end
`endif
    endtask

    task automatic test_flush_mid();
        int mid;
        bit mnew, bytes_ok;
        model_lookup(16'hA5A5, mid, mnew);
        run_pkt(16'hA5A5, 4, 1'b0, 2, 1'b0, 8'h00);
        model_flush();
        checks++;
        if (ls_id.size() != 1 || ls_id[0] !== 6'(mid) || ls_new[0] !== mnew || mid != 0 || mnew) begin
            failures++;
            $display("FAIL flush_cur_load: got id=%0d new=%b, required id=0 new=0", ls_id[0], ls_new[0]);
        end
        bytes_ok = (ch_dat.size() == 4);
        for (int i = 0; i < ch_dat.size() && i < 4; i++) if (ch_dat[i] !== exp_bytes[i]) bytes_ok = 1'b0;
        checks++;
        if (!bytes_ok || eop_cyc.size() != 1 || eop_id[0] !== 6'd0) begin
            failures++;
            $display("FAIL flush_cur_complete: got bytes=%0d eops=%0d eop_id=%0d, required 4 1 0",
                     ch_dat.size(), eop_cyc.size(), eop_id[0]);
        end
        model_lookup(16'hA5A5, mid, mnew);
        run_pkt(16'hA5A5, 2, 1'b0, -1, 1'b0, 8'h00);
        checks++;
        if (ls_id.size() != 1 || ls_id[0] !== 6'd0 || ls_new[0] !== 1'b1 || mid != 0 || !mnew) begin
            failures++;
            $display("FAIL flush_next_load: got id=%0d new=%b, required id=0 new=1", ls_id[0], ls_new[0]);
        end
    endtask

    task automatic test_wrap();
        int mid;
        bit mnew;
        int bad = 0;
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        model_flush();
        for (int i = 0; i < 65; i++) begin
            model_lookup(16'h1000 + 16'(i), mid, mnew);
            run_pkt(16'h1000 + 16'(i), 1, 1'b0, -1, 1'b0, 8'h00);
            checks++;
            if (ls_id.size() != 1 || ls_id[0] !== 6'(i % 64) || ls_new[0] !== 1'b1 || mid != i % 64) begin
                failures++; bad++;
                if (bad < 4) $display("FAIL wrap_alloc key%0d: got id=%0d new=%b, required id=%0d new=1",
                                      i, ls_id[0], ls_new[0], i % 64);
            end
        end
        model_lookup(16'h1000, mid, mnew);
        run_pkt(16'h1000, 2, 1'b1, -1, 1'b0, 8'h00);
        checks++;
        if (ls_id.size() != 1 || ls_id[0] !== 6'd1 || ls_new[0] !== 1'b1 || mid != 1) begin
            failures++;
            $display("FAIL wrap_evicted: got id=%0d new=%b, required id=1 new=1", ls_id[0], ls_new[0]);
        end
    endtask

    task automatic test_back_to_back();
        int mid, len;
        bit mnew, bytes_ok;
        logic [15:0] k;
        for (int p = 0; p < 24; p++) begin
            k = 16'h2000 + 16'($urandom_range(0, 5));
            len = $urandom_range(1, 6);
            model_lookup(k, mid, mnew);
            run_pkt(k, len, p[0], -1, 1'b0, 8'h00);
            checks++;
            if (ls_id.size() != 1 || ls_id[0] !== 6'(mid) || ls_new[0] !== mnew) begin
                failures++;
                $display("FAIL b2b_load pkt%0d key=%h: got id=%0d new=%b, required id=%0d new=%b",
                         p, k, ls_id[0], ls_new[0], mid, mnew);
            end
            bytes_ok = (ch_dat.size() == len);
            for (int i = 0; i < ch_dat.size() && i < len; i++) if (ch_dat[i] !== exp_bytes[i]) bytes_ok = 1'b0;
            checks++;
            if (!bytes_ok || ch_cyc[0] < ls_cyc[0] + 3 || eop_cyc.size() != 1 || eop_cyc[0] != ch_cyc[ch_cyc.size()-1] + 1) begin
                failures++;
                $display("FAIL b2b_stream pkt%0d: got bytes=%0d/%0d ls@%0d first@%0d eop@%0d, required match, first>=ls+3, eop=last+1",
                         p, ch_dat.size(), len, ls_cyc[0], ch_cyc[0], eop_cyc[0]);
            end
            checks++;
            if (ls_cyc[0] - prev_eop < 4) begin
                failures++;
                $display("FAIL b2b_gap pkt%0d: got load_state %0d cycles after eop, required >=4", p, ls_cyc[0] - prev_eop);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_single_beat();
        test_idle_drop();
        test_flush_mid();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
